// File: rtl/ltc_multi_ch_capture.sv
// Multi-lane LTC ADC capture: CNV/SCK generation, per-lane deserialisation, tagged words into a FWFT FIFO.
// First word 2+CONV_CYCLES+2*DATA_W+2 cycles after CNV; whole frame dropped (overflow set) when FIFO lacks room.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign rd_en  = rd_vld && rd_rdy;
  assign wr_en  = wr_vld && (count != (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ltc_multi_ch_capture #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int TS_W        = 8,
  parameter int CONV_CYCLES = 45,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              period,
  output logic                     cnv,
  output logic                     sck,
  input  logic [NUM_CH-1:0]        sdo,
  output logic [DATA_W+TS_W+3:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic                     busy
);
  localparam int MIN_PERIOD = 2 + CONV_CYCLES + 2*DATA_W + NUM_CH + 1;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, CNV, WAIT, SHIFT, CHECK, PUSH, HOLD} state_t;

  state_t              state, state_nxt;
  logic [15:0]         step, step_nxt;
  logic [15:0]         pcnt, eff_period;
  logic [TS_W-1:0]     frame_cnt, ts_q;
  logic [DATA_W-1:0]   shreg [NUM_CH];
  logic [DATA_W-1:0]   push_sample;
  logic [3:0]          ch_idx;
  logic [CW-1:0]       fifo_count;
  logic                frame_start, drop, push, fits;

  assign eff_period = (period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period;
  assign fits       = (FIFO_DEPTH - int'(fifo_count)) >= NUM_CH;
  assign push       = (state == PUSH);
  assign ch_idx     = step[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    frame_start = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt   = CNV;
        step_nxt    = '0;
        frame_start = 1'b1;
      end
      CNV: if (step == 16'd1) begin
        state_nxt = WAIT;
        step_nxt  = '0;
      end else step_nxt = step + 16'd1;
      WAIT: if (step == 16'(CONV_CYCLES-1)) begin
        state_nxt = SHIFT;
        step_nxt  = '0;
      end else step_nxt = step + 16'd1;
      SHIFT: if (step == 16'(2*DATA_W-1)) begin
        state_nxt = CHECK;
        step_nxt  = '0;
      end else step_nxt = step + 16'd1;
      CHECK: begin
        step_nxt = '0;
        if (fits) state_nxt = PUSH;
        else begin
          drop      = 1'b1;
          state_nxt = HOLD;
        end
      end
      PUSH: if (step == 16'(NUM_CH-1)) begin
        step_nxt = '0;
        // A frame exactly MIN_PERIOD long has no HOLD cycle at all
        if (pcnt != '0) state_nxt = HOLD;
        else if (enable) begin
          state_nxt   = CNV;
          frame_start = 1'b1;
        end else state_nxt = IDLE;
      end else step_nxt = step + 16'd1;
      HOLD: if (pcnt == '0) begin
        step_nxt = '0;
        if (enable) begin
          state_nxt   = CNV;
          frame_start = 1'b1;
        end else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt      <= '0;
      frame_cnt <= '0;
      ts_q      <= '0;
      cnv       <= 1'b0;
      sck       <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) shreg[c] <= '0;
    end else begin
      cnv  <= (state_nxt == CNV);
      sck  <= (state_nxt == SHIFT) && !step_nxt[0];
      busy <= (state_nxt != IDLE);
      if (frame_start) begin
        pcnt      <= eff_period - 16'd1;
        ts_q      <= frame_cnt;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (pcnt != '0) begin
        pcnt <= pcnt - 16'd1;
      end
      // Capture at the end of each sck-low half, i.e. after the falling edge
      if (state == SHIFT && step[0]) begin
        for (int c = 0; c < NUM_CH; c++) shreg[c] <= {shreg[c][DATA_W-2:0], sdo[c]};
      end
      if (drop) overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_comb begin
    push_sample = '0;
    for (int c = 0; c < NUM_CH; c++) if (ch_idx == 4'(c)) push_sample = shreg[c];
  end

  sync_fifo #(.W(DATA_W+TS_W+4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat ({ts_q, ch_idx, push_sample}),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat (m_data),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_ltc_multi_ch_capture.sv
// Directed bench for ltc_multi_ch_capture with a behavioural 4-lane ADC driving fixed words.
module tb_ltc_multi_ch_capture;
  localparam int MIN_PERIOD = 2 + 45 + 2*16 + 4 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd200;
  logic        cnv, sck, m_valid, overflow, busy;
  logic        m_ready = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [3:0]  sdo;
  logic [27:0] m_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [27:0] words[$];
  logic [15:0] lane_word [4] = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001};
  int bit_idx = -1;

  ltc_multi_ch_capture dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .cnv(cnv), .sck(sck), .sdo(sdo), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .overflow(overflow), .clear_ovf(clear_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: MSB valid after the first sck rise, next bit on each later rise
  always @(posedge cnv or posedge sck) begin
    if (cnv) bit_idx = -1;
    else bit_idx = bit_idx + 1;
  end

  always @* begin
    for (int c = 0; c < 4; c++)
      sdo[c] = (bit_idx >= 0 && bit_idx < 16) ? lane_word[c][15-bit_idx] : 1'b0;
  end

  always @(negedge clk) if (!reset && m_valid && m_ready) words.push_back(m_data);

  function automatic logic [27:0] exp_word(input logic [7:0] ts, input int ch);
    return {ts, 4'(ch), lane_word[ch]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; m_ready = 1'b0; clear_ovf = 1'b0; period = 16'd200;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    words.delete();
  endtask

  task automatic wait_cnv(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (cnv) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    tests_run++; if (cnv !== 1'b0) begin tests_failed++; $display("FAIL reset_cnv got %b want 0", cnv); end
    tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck got %b want 0", sck); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    tests_run++; if (m_data !== 28'h0) begin tests_failed++; $display("FAIL reset_m_data got %h want 0", m_data); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    bit ok;
    int cnv_hi, sck_p, first_mv;
    logic prev_sck;
    do_reset();
    period = 16'd200; m_ready = 1'b1; enable = 1'b1;
    wait_cnv(20, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_cnv_timeout got none want cnv"); end
    cnv_hi = 0; sck_p = 0; first_mv = -1; prev_sck = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cnv) cnv_hi++;
      if (sck && !prev_sck) sck_p++;
      prev_sck = sck;
      if (m_valid && first_mv < 0) first_mv = k;
      tick(1);
    end
    tests_run++; if (cnv_hi != 2) begin tests_failed++; $display("FAIL basic_cnv_width got %0d want 2", cnv_hi); end
    tests_run++; if (sck_p != 16) begin tests_failed++; $display("FAIL basic_sck_pulses got %0d want 16", sck_p); end
    tests_run++; if (first_mv != 81) begin tests_failed++; $display("FAIL basic_latency got %0d want 81", first_mv); end
    tests_run++; if (cnv !== 1'b1) begin tests_failed++; $display("FAIL basic_next_cnv got %b want 1", cnv); end
    tick(90);
    tests_run++;
    if (words.size() < 5) begin
      tests_failed++; $display("FAIL basic_word_count got %0d want >=5", words.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (words[i] !== exp_word(8'(i/4), i%4)) begin
          tests_failed++; $display("FAIL basic_word%0d got %h want %h", i, words[i], exp_word(8'(i/4), i%4));
        end
      end
    end
  endtask

  task automatic test_min_period();
    bit ok;
    int gap;
    do_reset();
    period = 16'd10; m_ready = 1'b1; enable = 1'b1;
    wait_cnv(20, ok);
    for (int f = 0; f < 2; f++) begin
      gap = -1;
      for (int k = 1; k < 300; k++) begin
        logic was;
        was = cnv;
        tick(1);
        if (cnv && !was) begin gap = k; break; end
      end
      tests_run++;
      if (gap != MIN_PERIOD) begin tests_failed++; $display("FAIL min_period_gap%0d got %0d want %0d", f, gap, MIN_PERIOD); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    period = 16'd200; m_ready = 1'b0; enable = 1'b1;
    wait_cnv(20, ok);
    tick(400);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before_drop got %b want 0", overflow); end
    tick(50);
    tests_run++; if (m_data !== exp_word(8'h00, 0)) begin tests_failed++; $display("FAIL ovf_head_stable got %h want %h", m_data, exp_word(8'h00, 0)); end
    tick(50);
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want 1", overflow); end
    tick(20);
    m_ready = 1'b1;
    tick(180);
    tests_run++;
    if (words.size() < 9) begin
      tests_failed++; $display("FAIL ovf_word_count got %0d want >=9", words.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (words[i] !== exp_word(8'(i/4), i%4)) begin
          tests_failed++; $display("FAIL ovf_word%0d got %h want %h", i, words[i], exp_word(8'(i/4), i%4));
        end
      end
      tests_run++;
      if (words[8] !== exp_word(8'h03, 0)) begin tests_failed++; $display("FAIL ovf_after_drop got %h want %h", words[8], exp_word(8'h03, 0)); end
    end
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_ts_wrap();
    bit ok;
    int bad;
    logic [27:0] w;
    do_reset();
    period = 16'd10; m_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 23000 && words.size() < 1040; k++) tick(1);
    tests_run++;
    if (words.size() < 1040) begin
      tests_failed++; $display("FAIL wrap_word_count got %0d want 1040", words.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 1040; i++) if (words[i] !== exp_word(8'((i/4) % 256), i%4)) bad++;
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL wrap_sequence got %0d bad words want 0", bad); end
      w = words[1020];
      tests_run++; if (w[27:20] !== 8'hFF) begin tests_failed++; $display("FAIL wrap_ts_ff got %h want ff", w[27:20]); end
      w = words[1024];
      tests_run++; if (w[27:20] !== 8'h00) begin tests_failed++; $display("FAIL wrap_ts_00 got %h want 00", w[27:20]); end
    end
    ok = 1'b1;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int extra;
    logic was;
    do_reset();
    period = 16'd200; m_ready = 1'b1; enable = 1'b1;
    wait_cnv(20, ok);
    tick(60);
    enable = 1'b0;
    extra = 0;
    for (int k = 0; k < 240; k++) begin
      was = cnv;
      tick(1);
      if (cnv && !was) extra++;
    end
    tests_run++; if (words.size() != 4) begin tests_failed++; $display("FAIL endrop_word_count got %0d want 4", words.size()); end
    tests_run++;
    if (words.size() >= 4 && words[3] !== exp_word(8'h00, 3)) begin
      tests_failed++; $display("FAIL endrop_word3 got %h want %h", words[3], exp_word(8'h00, 3));
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL endrop_busy got %b want 0", busy); end
    tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL endrop_extra_cnv got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    period = 16'd200; m_ready = 1'b0; enable = 1'b1;
    wait_cnv(20, ok);
    tick(261);
    tests_run++; if (sck !== 1'b1) begin tests_failed++; $display("FAIL rstmid_sck_before got %b want 1", sck); end
    tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_valid_before got %b want 1", m_valid); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL rstmid_sck got %b want 0", sck); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_m_valid got %b want 0", m_valid); end
    tests_run++; if (cnv !== 1'b0) begin tests_failed++; $display("FAIL rstmid_cnv got %b want 0", cnv); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tick(2);
    reset = 1'b0;
    m_ready = 1'b1;
    words.delete();
    for (int k = 0; k < 300 && words.size() == 0; k++) tick(1);
    tests_run++;
    if (words.size() == 0) begin
      tests_failed++; $display("FAIL rstmid_timeout got no word want one");
    end else if (words[0] !== exp_word(8'h00, 0)) begin
      tests_failed++; $display("FAIL rstmid_first_word got %h want %h", words[0], exp_word(8'h00, 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_min_period();
    test_overflow();
    test_ts_wrap();
    test_enable_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
